// File: rtl/gray_seq_ctrl_pkg.sv
// Shared definitions for the Gray-code sequencer.
//   state_t        : FSM state encoding (IDLE/RUN/DONE)
//   DIR_UP/DIR_DN  : encodings of the dir input
package gray_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/bin2gray_conv.sv
// Binary to reflected-Gray converter, purely combinational.
//   bin  : binary input, WIDTH bits
//   gray : bin ^ (bin >> 1)
module bin2gray_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Sequencer stepping a binary count from start_val toward limit (or free-running),
// presenting each value and its Gray code on a valid/ready stream.
//   clk, rst              : clock, synchronous active-high reset
//   start, stop           : begin a sequence (IDLE only) / abort a running one
//   dir, wrap             : count down when 1 / ignore limit when 1 (latched at start)
//   start_val, limit      : first value / last value when wrap=0 (latched at start)
//   out_ready             : consumer accepts the presented value
//   out_valid             : bin_out/gray_out carry a value to transfer
//   bin_out, gray_out     : registered count and its Gray code
//   busy                  : FSM in RUN
//   done                  : one-cycle pulse after the limit value was transferred
module gray_seq_ctrl
  import gray_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_q, bin_nxt;
  logic [WIDTH-1:0] limit_q, limit_nxt;
  logic             dir_q, dir_nxt;
  logic             wrap_q, wrap_nxt;
  logic             xfer;

  // Next count value; natural modulo-2^WIDTH wrap in both directions.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                  input logic             d);
    return (d == DIR_UP) ? (cur + ONE) : (cur - ONE);
  endfunction

  assign xfer = (state == RUN) && out_ready;

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    limit_nxt = limit_q;
    dir_nxt   = dir_q;
    wrap_nxt  = wrap_q;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          bin_nxt   = start_val;
          limit_nxt = limit;
          dir_nxt   = dir;
          wrap_nxt  = wrap;
        end
      end
      RUN: begin
        // The final value stays on bin_out; a stop during that transfer
        // suppresses the done pulse but the transfer itself still happened.
        if (xfer) begin
          if (!wrap_q && (bin_q == limit_q)) begin
            state_nxt = stop ? IDLE : DONE;
          end else begin
            bin_nxt = step_count(bin_q, dir_q);
          end
        end
        if (stop) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, count and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_q   <= '0;
      limit_q <= '0;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bin_q   <= bin_nxt;
      limit_q <= limit_nxt;
      dir_q   <= dir_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign bin_out   = bin_q;

  bin2gray_conv #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .bin (bin_q),
    .gray(gray_out)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             dir;
  logic             wrap;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] limit;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  gray_seq_ctrl #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .wrap     (wrap),
    .start_val(start_val),
    .limit    (limit),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Hand-computed Gray codes for bin 0..15.
  logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] b,
                         input logic [3:0] g, input logic bz, input logic d);
    chk({tag, ".valid"}, 16'(out_valid), 16'(v));
    chk({tag, ".bin"},   16'(bin_out),   16'(b));
    chk({tag, ".gray"},  16'(gray_out),  16'(g));
    chk({tag, ".busy"},  16'(busy),      16'(bz));
    chk({tag, ".done"},  16'(done),      16'(d));
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] sv, input logic [3:0] lim,
                        input logic d, input logic w);
    start_val = sv;
    limit     = lim;
    dir       = d;
    wrap      = w;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; wrap = 1'b0;
    start_val = '0; limit = '0; out_ready = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("idle", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 1: full up-count 0..15, full rate
    out_ready = 1'b1;
    launch(4'd0, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("t1[%0d]", i), 1'b1, 4'(i), gray_tbl[i], 1'b1, 1'b0);
      tick();
    end
    chk_out("t1.done", 1'b0, 4'd15, 4'b1000, 1'b0, 1'b1);
    tick();
    chk_out("t1.idle", 1'b0, 4'd15, 4'b1000, 1'b0, 1'b0);

    // 2: backpressure at 5
    launch(4'd3, 4'd15, 1'b0, 1'b0);
    chk_out("t2.first", 1'b1, 4'd3, 4'b0010, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("t2.at5", 1'b1, 4'd5, 4'b0111, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("t2.hold[%0d]", i), 1'b1, 4'd5, 4'b0111, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk_out("t2.next", 1'b1, 4'd6, 4'b0101, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("t2.stop", 1'b0, 4'd7, 4'b0100, 1'b0, 1'b0);

    // 3: down-count through zero to 14
    launch(4'd2, 4'd14, 1'b1, 1'b0);
    chk_out("t3[0]", 1'b1, 4'd2,  4'b0011, 1'b1, 1'b0); tick();
    chk_out("t3[1]", 1'b1, 4'd1,  4'b0001, 1'b1, 1'b0); tick();
    chk_out("t3[2]", 1'b1, 4'd0,  4'b0000, 1'b1, 1'b0); tick();
    chk_out("t3[3]", 1'b1, 4'd15, 4'b1000, 1'b1, 1'b0); tick();
    chk_out("t3[4]", 1'b1, 4'd14, 4'b1001, 1'b1, 1'b0); tick();
    chk_out("t3.done", 1'b0, 4'd14, 4'b1001, 1'b0, 1'b1);
    tick();
    chk_out("t3.idle", 1'b0, 4'd14, 4'b1001, 1'b0, 1'b0);

    // 4: free-run wraps past limit=15, stop during the transfer of 1
    launch(4'd14, 4'd15, 1'b0, 1'b1);
    chk_out("t4[0]", 1'b1, 4'd14, 4'b1001, 1'b1, 1'b0); tick();
    chk_out("t4[1]", 1'b1, 4'd15, 4'b1000, 1'b1, 1'b0); tick();
    chk_out("t4[2]", 1'b1, 4'd0,  4'b0000, 1'b1, 1'b0); tick();
    chk_out("t4[3]", 1'b1, 4'd1,  4'b0001, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("t4.stop", 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0);
    tick();
    chk_out("t4.nodone", 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0);

    // 5: reset mid-run, start held with reset
    out_ready = 1'b0;
    launch(4'd9, 4'd12, 1'b0, 1'b0);
    chk_out("t5.run", 1'b1, 4'd9, 4'b1101, 1'b1, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk_out("t5.rst", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk_out("t5.idle", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 6: start+stop in IDLE, start ignored in RUN, start_val==limit
    start = 1'b1;
    stop  = 1'b1;
    start_val = 4'd4;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_out("t6.ststp", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
    launch(4'd7, 4'd7, 1'b0, 1'b0);
    chk_out("t6.run", 1'b1, 4'd7, 4'b0100, 1'b1, 1'b0);
    start_val = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t6.restart", 1'b1, 4'd7, 4'b0100, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("t6.done", 1'b0, 4'd7, 4'b0100, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t6.idle", 1'b0, 4'd7, 4'b0100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
